ir_transmitter: RTL



---
 rtl/ir_uart_pkg.sv | 25 ++
 rtl/ir_tx_baud_tick.sv | 46 ++++
 rtl/ir_transmitter.sv | 98 +++++++++
 3 files changed

// File: rtl/ir_uart_pkg.sv
// rtl/ir_uart_pkg.sv - shared IrDA UART frame layout, state encoding and helpers
package ir_uart_pkg;

  // Frame layout shared with the IR receiver's data_received[10:0]
  localparam int FRAME_BITS = 11;
  localparam int STOP_IDX   = 10;
  localparam int PAR_IDX    = 9;
  localparam int START_IDX  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ir_state_t;

  // Bits needed to hold the values 0..value-1
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/ir_tx_baud_tick.sv
// rtl/ir_tx_baud_tick.sv - baud counter with terminal-count tick and IR pulse window
module ir_tx_baud_tick
  import ir_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PULSE_CLKS   = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic pulse_window
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;

  assign tick = en && !clr && (count == CNT_W'(CLKS_PER_BIT - 1));

  // Next count: clear wins, terminal count wraps to zero, otherwise advance when enabled
  always_comb begin
    count_d = count;
    if (clr || tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count + 1'b1;
    end
  end

  // Window is evaluated on the count about to be loaded, so the caller can
  // register tx_ir in the same edge and keep it aligned with tx_uart.
  assign pulse_window = (count_d < CNT_W'(PULSE_CLKS));

  // Counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/ir_transmitter.sv
// rtl/ir_transmitter.sv - UART-framed IrDA transmitter with NRZ and 3/16 RZ outputs
module ir_transmitter
  import ir_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_8bitdata,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_uart,
  output logic       tx_ir
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int PULSE_RAW    = (CLKS_PER_BIT * 3) / 16;
  localparam int PULSE_CLKS   = (PULSE_RAW < 1) ? 1 : PULSE_RAW;

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("ir_transmitter: CLK_FREQ/BAUD must be at least 2");
  end

  ir_state_t             state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [3:0]            bit_cnt;
  logic                  tick;
  logic                  pulse_window;
  logic                  parity;

  assign parity = (^tx_8bitdata) ^ (PARITY_ODD != 0);

  ir_tx_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PULSE_CLKS   (PULSE_CLKS)
  ) u_baud (
    .clock        (clock),
    .reset        (reset),
    .en           (state == SEND),
    .clr          (state == IDLE),
    .tick         (tick),
    .pulse_window (pulse_window)
  );

  // Frame sequencer; every output is registered and reflects the bit now on the line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '1;
      bit_cnt   <= '0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_uart   <= 1'b1;
      tx_ir     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            shift_reg <= {1'b1, parity, tx_8bitdata, 1'b0};
            bit_cnt   <= '0;
            state     <= SEND;
            tx_busy   <= 1'b1;
            tx_uart   <= 1'b0;
            tx_ir     <= pulse_window;
          end else begin
            tx_uart <= 1'b1;
            tx_ir   <= 1'b0;
          end
        end
        SEND: begin
          if (tick) begin
            if (bit_cnt == 4'(STOP_IDX)) begin
              state   <= IDLE;
              bit_cnt <= '0;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              tx_uart <= 1'b1;
              tx_ir   <= 1'b0;
            end else begin
              shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
              bit_cnt   <= bit_cnt + 4'd1;
              tx_uart   <= shift_reg[1];
              tx_ir     <= !shift_reg[1] && pulse_window;
            end
          end else begin
            tx_ir <= !shift_reg[0] && pulse_window;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
